// File: rtl/xbar_switch.sv
// xbar_switch: NPORTS x NPORTS crossbar, one-hot select per output,
// registered outputs with atomic multicast and sticky select errors.
module xbar_switch #(
  parameter int NPORTS = 3,
  parameter int DW     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS*DW-1:0]       in_data,
  input  logic [NPORTS-1:0]          in_valid,
  output logic [NPORTS-1:0]          in_ready,
  input  logic [NPORTS*NPORTS-1:0]   sel,
  output logic [NPORTS*DW-1:0]       out_data,
  output logic [NPORTS-1:0]          out_valid,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [NPORTS-1:0]          sel_err,
  input  logic                       err_clr
);

  logic [NPORTS-1:0]         legal;
  logic [NPORTS-1:0]         space;
  logic [NPORTS-1:0]         hit;
  logic [NPORTS-1:0]         blk;
  logic [NPORTS-1:0]         fire;
  logic [NPORTS-1:0]         load;
  logic [NPORTS-1:0][DW-1:0] nxt;

  function automatic logic onehot(input logic [NPORTS-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < NPORTS; k++) begin
      if (v[k]) c++;
    end
    return c == 1;
  endfunction

  always_comb begin
    legal = '0;
    space = '0;
    for (int j = 0; j < NPORTS; j++) begin
      legal[j] = onehot(sel[j*NPORTS +: NPORTS]);
      space[j] = ~out_valid[j] | out_ready[j];
    end
  end

  // An input is ready only when every legal reader has room,
  // so a multicast flit lands everywhere or nowhere.
  always_comb begin
    hit      = '0;
    blk      = '0;
    in_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (legal[j] && sel[j*NPORTS+i]) begin
          hit[i] = 1'b1;
          if (!space[j]) blk[i] = 1'b1;
        end
      end
      in_ready[i] = ~rst & hit[i] & ~blk[i];
    end
  end

  assign fire = in_valid & in_ready;

  always_comb begin
    load = '0;
    nxt  = '0;
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (legal[j] && sel[j*NPORTS+i] && fire[i]) begin
          load[j] = 1'b1;
          nxt[j]  = in_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (load[j]) begin
          out_valid[j]           <= 1'b1;
          out_data[j*DW +: DW]   <= nxt[j];
        end else if (out_ready[j]) begin
          out_valid[j]           <= 1'b0;
        end
      end
      sel_err <= (sel_err & ~{NPORTS{err_clr}}) | ~legal;
    end
  end

endmodule

// File: tb/tb_xbar_switch.sv
// tb_xbar_switch: directed checks on a 3-port/64-bit switch and a
// randomised scoreboard soak on a 4-port/32-bit switch.
module tb_xbar_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        err_clr;
  logic [3:0]  selm [4];
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [63:0] idat [4];

  logic [191:0] d3_in;
  logic [8:0]   s3;
  logic [2:0]   r3, v3, e3;
  logic [191:0] d3;
  logic [127:0] d4_in;
  logic [15:0]  s4;
  logic [3:0]   r4, v4, e4;
  logic [127:0] d4;

  assign d3_in = {idat[2], idat[1], idat[0]};
  assign s3    = {selm[2][2:0], selm[1][2:0], selm[0][2:0]};
  assign d4_in = {idat[3][31:0], idat[2][31:0], idat[1][31:0], idat[0][31:0]};
  assign s4    = {selm[3], selm[2], selm[1], selm[0]};

  xbar_switch #(.NPORTS(3), .DW(64)) u3 (
    .clk(clk), .rst(rst), .in_data(d3_in), .in_valid(iv[2:0]),
    .in_ready(r3), .sel(s3), .out_data(d3), .out_valid(v3),
    .out_ready(ordy[2:0]), .sel_err(e3), .err_clr(err_clr)
  );

  xbar_switch #(.NPORTS(4), .DW(32)) u4 (
    .clk(clk), .rst(rst), .in_data(d4_in), .in_valid(iv),
    .in_ready(r4), .sel(s4), .out_data(d4), .out_valid(v4),
    .out_ready(ordy), .sel_err(e4), .err_clr(err_clr)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n = 3;
  bit          sb_on = 0;
  bit          mv [4];
  logic [63:0] md [4];
  bit          me [4];
  int unsigned seq [4];
  int unsigned q [4][4][$];
  logic [3:0]  rdy_s;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic act_rdy(input int i);
    return (n == 3) ? r3[i] : r4[i];
  endfunction

  function automatic logic act_ov(input int j);
    return (n == 3) ? v3[j] : v4[j];
  endfunction

  function automatic logic act_se(input int j);
    return (n == 3) ? e3[j] : e4[j];
  endfunction

  function automatic logic [63:0] act_od(input int j);
    return (n == 3) ? d3[j*64 +: 64] : {32'b0, d4[j*32 +: 32]};
  endfunction

  function automatic bit legal(input logic [3:0] s);
    logic [3:0] m;
    m = (n == 3) ? 4'h7 : 4'hF;
    return $countones(s & m) == 1;
  endfunction

  function automatic int srcof(input logic [3:0] s);
    for (int k = 0; k < 4; k++) if (s[k]) return k;
    return 0;
  endfunction

  function automatic logic [3:0] exp_rdy();
    logic [3:0] r;
    bit any, ok;
    r = '0;
    for (int i = 0; i < n; i++) begin
      any = 0;
      ok  = 1;
      for (int j = 0; j < n; j++) begin
        if (legal(selm[j]) && selm[j][i]) begin
          any = 1;
          if (mv[j] && !ordy[j]) ok = 0;
        end
      end
      r[i] = !rst && any && ok;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 4; j++) begin
      mv[j] = 0;
      md[j] = '0;
      me[j] = 0;
    end
  endtask

  task automatic check_outs();
    for (int j = 0; j < n; j++) begin
      check($sformatf("ov%0d", j), 64'(act_ov(j)), 64'(mv[j]));
      check($sformatf("od%0d", j), act_od(j), md[j]);
      check($sformatf("se%0d", j), 64'(act_se(j)), 64'(me[j]));
    end
  endtask

  task automatic cyc();
    logic [3:0]  er;
    logic [63:0] od;
    int          s;
    bit          ok;
    bit          lg;
    #3;
    er = exp_rdy();
    for (int i = 0; i < n; i++) begin
      rdy_s[i] = act_rdy(i);
      check($sformatf("rdy%0d", i), 64'(rdy_s[i]), 64'(er[i]));
    end
    if (sb_on) begin
      for (int j = 0; j < n; j++) begin
        if (act_ov(j) && ordy[j]) begin
          od = act_od(j);
          s  = int'(od[31:24]);
          ok = (s < 4) && (q[s][j].size() != 0);
          check($sformatf("sb_has%0d", j), 64'(ok), 64'd1);
          if (ok)
            check($sformatf("sb_seq%0d_%0d", s, j), {40'b0, od[23:0]},
                  64'(q[s][j].pop_front() & 24'hFFFFFF));
        end
      end
      for (int i = 0; i < n; i++) begin
        if (iv[i] && act_rdy(i)) begin
          for (int j = 0; j < n; j++)
            if (legal(selm[j]) && selm[j][i]) q[i][j].push_back(seq[i]);
          seq[i]++;
        end
      end
    end
    if (rst) model_clear();
    else begin
      for (int j = 0; j < n; j++) begin
        lg = legal(selm[j]);
        s  = srcof(selm[j]);
        if (lg && iv[s] && er[s]) begin
          mv[j] = 1;
          md[j] = (n == 3) ? idat[s] : {32'b0, idat[s][31:0]};
        end else if (ordy[j]) begin
          mv[j] = 0;
        end
        me[j] = (me[j] && !err_clr) || !lg;
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic rand_stim();
    logic [3:0] m;
    m = (n == 3) ? 4'h7 : 4'hF;
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0)
          selm[j] = 4'($urandom_range(0, 15)) & m;
        else
          selm[j] = 4'(1 << $urandom_range(0, n - 1));
      end
    end
    iv      = 4'($urandom) & m;
    ordy    = 4'($urandom) & m;
    err_clr = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < n; i++)
      idat[i] = sb_on ? {32'b0, 8'(i), 24'(seq[i])} : {$urandom, $urandom};
  endtask

  logic [63:0] hold;

  initial begin
    rst = 1; err_clr = 0; iv = '0; ordy = '0;
    selm[0] = 4'h1; selm[1] = 4'h2; selm[2] = 4'h4; selm[3] = 4'h8;
    for (int i = 0; i < 4; i++) begin idat[i] = '0; seq[i] = 0; end
    model_clear();
    #2;
    check_outs();
    for (int i = 0; i < n; i++) check("rst_rdy", 64'(act_rdy(i)), 64'd0);
    @(posedge clk); #1;
    cyc();
    rst = 0;

    // unicast identity mapping
    iv = 4'b0111; ordy = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) idat[i] = {$urandom, $urandom};
      cyc();
      check("uni_rdy", 64'(rdy_s[2:0]), 64'h7);
      for (int j = 0; j < 3; j++)
        check($sformatf("uni_d%0d", j), act_od(j), idat[j]);
    end

    // backpressure on output 1 while it reads input 0
    hold = idat[1];
    selm[1] = 4'h1; ordy = 4'b0101;
    for (int i = 0; i < 3; i++) idat[i] = {$urandom, $urandom};
    cyc();
    check("bp_rdy0", 64'(rdy_s[0]), 64'd0);
    check("bp_hold", act_od(1), hold);
    ordy = 4'b0111;
    idat[0] = {$urandom, $urandom};
    cyc();
    check("bp_rdy0_go", 64'(rdy_s[0]), 64'd1);
    check("bp_load", act_od(1), idat[0]);
    check("bp_ov1", 64'(act_ov(1)), 64'd1);

    // multicast input 1 to outputs 0 and 2, output 2 stalled
    selm[0] = 4'h2; selm[2] = 4'h2; ordy = 4'b0011;
    idat[1] = {$urandom, $urandom};
    cyc();
    check("mc_rdy1", 64'(rdy_s[1]), 64'd0);
    check("mc_noload", 64'(act_ov(0)), 64'd0);
    ordy = 4'b0111;
    cyc();
    check("mc_d0", act_od(0), idat[1]);
    check("mc_d2", act_od(2), idat[1]);

    // illegal select on output 1 and sticky error
    selm[1] = 4'h3;
    cyc();
    check("ill_err", 64'({act_se(2), act_se(1), act_se(0)}), 64'h2);
    check("ill_noload", 64'(act_ov(1)), 64'd0);
    selm[1] = 4'h2;
    cyc();
    check("ill_sticky", 64'(act_se(1)), 64'd1);
    err_clr = 1;
    cyc();
    check("ill_clr", 64'({act_se(2), act_se(1), act_se(0)}), 64'h0);
    selm[1] = 4'h3;
    cyc();
    check("ill_setwins", 64'(act_se(1)), 64'd1);
    selm[1] = 4'h2;
    cyc();
    err_clr = 0;

    // reset while outputs hold flits
    ordy = 4'b0000; iv = 4'b0111;
    cyc();
    cyc();
    rst = 1;
    #1;
    model_clear();
    check_outs();
    for (int i = 0; i < 3; i++) check("mid_rdy", 64'(act_rdy(i)), 64'd0);
    cyc();
    rst = 0; ordy = 4'b0111;
    for (int i = 0; i < 3; i++) idat[i] = {$urandom, $urandom};
    cyc();
    check("rst_lat", act_od(1), idat[1]);

    for (int k = 0; k < 300; k++) begin
      rand_stim();
      cyc();
    end

    // scoreboard soak on the 4-port instance
    rst = 1; err_clr = 0;
    n = 4;
    model_clear();
    cyc();
    selm[3] = 4'h8;
    rst = 0; sb_on = 1;
    for (int k = 0; k < 3000; k++) begin
      rand_stim();
      cyc();
    end
    err_clr = 0; iv = '0; ordy = 4'hF;
    for (int j = 0; j < 4; j++) selm[j] = 4'(1 << j);
    for (int k = 0; k < 4; k++) cyc();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("sb_left%0d_%0d", i, j), 64'(q[i][j].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
